// File: rtl/irq_ctrl.sv
// Interrupt controller: rising-edge capture, pending hold and single-winner dispatch to fetch.
// Optional macro IRQ_ROUND_ROBIN_EN selects a rotating-pointer arbiter instead of fixed priority.
module irq_ctrl #(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        irq_req,
    input  logic [NUM_SRC*DATA_W-1:0] irq_data,
    input  logic [NUM_SRC-1:0]        irq_mask,
    input  logic                      mem_busy,
    input  logic                      ret,
    output logic                      interrupt,
    output logic [2:0]                irq_id,
    output logic [DATA_W-1:0]         source_data,
    output logic                      in_service,
    output logic [NUM_SRC-1:0]        pending
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_SERVICE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] req_q;
    logic               cap_en_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clr;
    logic [2:0]         win_idx;
    logic               dispatch;
    logic [2:0]         start_idx;

    // First index with e set, searching upward from start and wrapping.
    function automatic logic [2:0] pick(input logic [NUM_SRC-1:0] e, input logic [2:0] start);
        logic [2:0] w;
        logic       hit;
        int         idx;
        w   = 3'd0;
        hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!hit && e[idx]) begin
                hit = 1'b1;
                w   = 3'(idx);
            end
        end
        return w;
    endfunction

    // Captures are suppressed on the first edge after reset so a level already
    // high when reset releases is recorded in req_q but never seen as an edge.
    assign rise = irq_req & ~req_q & {NUM_SRC{cap_en_q}};
    assign elig = pending & ~irq_mask;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [2:0] ptr_q;

    assign start_idx = ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 3'd0;
        end else if (dispatch) begin
            ptr_q <= (int'(win_idx) == NUM_SRC - 1) ? 3'd0 : win_idx + 3'd1;
        end
    end
`else
    assign start_idx = 3'd0;
`endif

    assign win_idx  = pick(elig, start_idx);
    assign dispatch = (state_q == S_IDLE) && (|elig) && !mem_busy;
    assign clr      = dispatch ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << win_idx) : '0;

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (dispatch) state_d = S_FIRE;
            S_FIRE:    state_d = S_SERVICE;
            S_SERVICE: if (ret) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            cap_en_q    <= 1'b0;
            pending     <= '0;
            interrupt   <= 1'b0;
            in_service  <= 1'b0;
            irq_id      <= 3'd0;
            source_data <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= irq_req;
            cap_en_q   <= 1'b1;
            // A new edge on the winner in its dispatch cycle survives the clear.
            pending    <= (pending & ~clr) | rise;
            interrupt  <= (state_d == S_FIRE);
            in_service <= (state_d != S_IDLE);
            if (dispatch) begin
                irq_id      <= win_idx;
                source_data <= irq_data[win_idx*DATA_W +: DATA_W];
            end
        end
    end

endmodule
